// File: rtl/proc_n.sv
// Parametrised multicycle processor: 8 x N-bit register file, Run/Done sequencing over
// steps T0..T3, ALU with add/sub/and/cmp/shift, Z/Nf/C flags and a debug read port.
module proc_n #(
   parameter int unsigned N = 16
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic [15:0]  DIN,
   input  logic         Run,
   output logic         Done,
   output logic         Z,
   output logic         Nf,
   output logic         C,
   input  logic [2:0]   DbgSel,
   output logic [N-1:0] DbgData
);

   localparam int unsigned SW = $clog2(N);

   typedef enum logic [1:0] {StT0, StT1, StT2, StT3} step_e;
   typedef enum logic [2:0] {
      OpMv, OpMvt, OpAdd, OpSub, OpAnd, OpCmp, OpShift, OpMvnz
   } op_e;

   step_e        step_q, step_d;
   logic [15:0]  ir_q, ir_d;
   logic [N-1:0] r_q [8];
   logic [N-1:0] r_d [8];
   logic [N-1:0] a_q, a_d, g_q, g_d;
   logic         z_q, z_d, nf_q, nf_d, c_q, c_d;
   logic         done;

   op_e          opc;
   logic [2:0]   rx, ry;
   logic         is_alu;
   logic [N-1:0] op, mvt_val;
   logic [N:0]   add_ext, shl_ext, shr_ext;
   logic [SW-1:0] amt;
   logic [N-1:0] alu_res;
   logic         alu_c;

   assign opc     = op_e'(ir_q[15:13]);
   assign rx      = ir_q[11:9];
   assign ry      = ir_q[2:0];
   assign is_alu  = (opc != OpMv) && (opc != OpMvt) && (opc != OpMvnz);
   assign mvt_val = {ir_q[7:0], {(N-8){1'b0}}};

   // Immediate shifts reserve IR[8] for the shift type, so only IR[7:0] is the operand.
   always_comb begin
      if (!ir_q[12]) begin
         op = r_q[ry];
      end else if (opc == OpShift) begin
         op = {{(N-8){1'b0}}, ir_q[7:0]};
      end else begin
         op = {{(N-9){1'b0}}, ir_q[8:0]};
      end
   end

   // Shifting through one extra bit leaves the last bit shifted out in that bit.
   assign amt     = op[SW-1:0];
   assign add_ext = {1'b0, a_q} + {1'b0, op};
   assign shl_ext = {1'b0, a_q} << amt;
   assign shr_ext = {a_q, 1'b0} >> amt;

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      unique case (opc)
         OpAdd: begin
            alu_res = add_ext[N-1:0];
            alu_c   = add_ext[N];
         end
         OpSub, OpCmp: begin
            alu_res = a_q - op;
            alu_c   = (a_q >= op);
         end
         OpAnd: begin
            alu_res = a_q & op;
         end
         OpShift: begin
            if (ir_q[8]) begin
               alu_res = shr_ext[N:1];
               alu_c   = shr_ext[0];
            end else begin
               alu_res = shl_ext[N-1:0];
               alu_c   = shl_ext[N];
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      step_d = step_q;
      ir_d   = ir_q;
      r_d    = r_q;
      a_d    = a_q;
      g_d    = g_q;
      z_d    = z_q;
      nf_d   = nf_q;
      c_d    = c_q;
      done   = 1'b0;
      unique case (step_q)
         StT0: begin
            ir_d = DIN;
            if (Run) step_d = StT1;
         end
         StT1: begin
            if (is_alu) begin
               a_d    = r_q[rx];
               step_d = StT2;
            end else begin
               done   = 1'b1;
               step_d = StT0;
               if (opc == OpMv) r_d[rx] = op;
               if (opc == OpMvt) r_d[rx] = mvt_val;
               if (opc == OpMvnz && !z_q) r_d[rx] = op;
            end
         end
         StT2: begin
            g_d    = alu_res;
            z_d    = (alu_res == '0);
            nf_d   = alu_res[N-1];
            c_d    = alu_c;
            step_d = StT3;
         end
         StT3: begin
            done   = 1'b1;
            step_d = StT0;
            if (opc != OpCmp) r_d[rx] = g_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         step_q <= StT0;
         ir_q   <= '0;
         a_q    <= '0;
         g_q    <= '0;
         z_q    <= 1'b0;
         nf_q   <= 1'b0;
         c_q    <= 1'b0;
         for (int i = 0; i < 8; i++) r_q[i] <= '0;
      end else begin
         step_q <= step_d;
         ir_q   <= ir_d;
         a_q    <= a_d;
         g_q    <= g_d;
         z_q    <= z_d;
         nf_q   <= nf_d;
         c_q    <= c_d;
         for (int i = 0; i < 8; i++) r_q[i] <= r_d[i];
      end
   end

   assign Done    = done;
   assign Z       = z_q;
   assign Nf      = nf_q;
   assign C       = c_q;
   assign DbgData = r_q[DbgSel];

endmodule

// File: tb/tb_proc_n.sv
// Drives identical instruction streams into N=16 and N=32 instances and checks both
// against an arithmetic reference model of the instruction set.
module tb_proc_n;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [15:0] DIN;
   logic        Run;
   logic [2:0]  DbgSel;
   logic        done16, z16, nf16, c16;
   logic        done32, z32, nf32, c32;
   logic [15:0] dbg16;
   logic [31:0] dbg32;

   always #5 Clock = ~Clock;

   proc_n #(.N(16)) dut16 (
      .Clock(Clock), .Reset(Reset), .DIN(DIN), .Run(Run), .Done(done16),
      .Z(z16), .Nf(nf16), .C(c16), .DbgSel(DbgSel), .DbgData(dbg16)
   );

   proc_n #(.N(32)) dut32 (
      .Clock(Clock), .Reset(Reset), .DIN(DIN), .Run(Run), .Done(done32),
      .Z(z32), .Nf(nf32), .C(c32), .DbgSel(DbgSel), .DbgData(dbg32)
   );

   int          n_assert = 0;
   int          n_fail = 0;
   logic [63:0] mr [2][8];
   logic        mz [2];
   logic        mn [2];
   logic        mc [2];
   int unsigned wd [2] = '{16, 32};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] enc(input logic [2:0] o, input logic m,
                                       input logic [2:0] x, input logic [8:0] d);
      return {o, m, x, d};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 8; i++) mr[k][i] = '0;
         mz[k] = 1'b0;
         mn[k] = 1'b0;
         mc[k] = 1'b0;
      end
   endtask

   task automatic model_exec(input int k, input logic [15:0] ins, output int lat);
      logic [2:0]  opc;
      logic [2:0]  rx;
      int unsigned w;
      logic [63:0] mask, a, op, res, t;
      logic [5:0]  amsk, amt;
      opc  = ins[15:13];
      rx   = ins[11:9];
      w    = wd[k];
      mask = (64'd1 << w) - 64'd1;
      amsk = 6'((32'd1 << $clog2(w)) - 32'd1);
      a    = mr[k][rx];
      if (!ins[12]) op = mr[k][ins[2:0]];
      else if (opc == 3'd6) op = {56'd0, ins[7:0]};
      else op = {55'd0, ins[8:0]};
      lat = (opc == 3'd0 || opc == 3'd1 || opc == 3'd7) ? 2 : 4;
      res = '0;
      case (opc)
         3'd0: mr[k][rx] = op;
         3'd1: mr[k][rx] = ({56'd0, ins[7:0]} << (w - 8)) & mask;
         3'd7: if (!mz[k]) mr[k][rx] = op;
         default: begin
            case (opc)
               3'd2: begin
                  t = a + op;
                  res = t & mask;
                  mc[k] = t[w];
               end
               3'd3, 3'd5: begin
                  res = (a - op) & mask;
                  mc[k] = (a >= op);
               end
               3'd4: begin
                  res = a & op;
                  mc[k] = 1'b0;
               end
               default: begin
                  amt = op[5:0] & amsk;
                  if (!ins[8]) begin
                     t = a << amt;
                     res = t & mask;
                     mc[k] = t[w];
                  end else begin
                     res = a >> amt;
                     mc[k] = (amt == 0) ? 1'b0 : a[amt-1];
                  end
               end
            endcase
            if (opc != 3'd5) mr[k][rx] = res;
            mz[k] = (res == 0);
            mn[k] = res[w-1];
         end
      endcase
   endtask

   // Runs one instruction; with hold set Run stays high for a back-to-back successor.
   task automatic exec(input logic [15:0] ins, input bit hold);
      int lat, lat32;
      logic [2:0] rx;
      rx = ins[11:9];
      model_exec(0, ins, lat);
      model_exec(1, ins, lat32);
      @(negedge Clock);
      DIN = ins;
      Run = 1'b1;
      DbgSel = rx;
      check("done_t0_16", {63'd0, done16}, 64'd0);
      check("done_t0_32", {63'd0, done32}, 64'd0);
      @(posedge Clock);
      #1;
      if (!hold) Run = 1'b0;
      for (int c = 2; c <= lat; c++) begin
         @(negedge Clock);
         check($sformatf("done16_%h_c%0d", ins, c), {63'd0, done16}, {63'd0, c == lat});
         check($sformatf("done32_%h_c%0d", ins, c), {63'd0, done32}, {63'd0, c == lat});
      end
      @(posedge Clock);
      #1;
      check($sformatf("reg16_%h", ins), {48'd0, dbg16}, mr[0][rx]);
      check($sformatf("reg32_%h", ins), {32'd0, dbg32}, mr[1][rx]);
      check($sformatf("flags16_%h", ins), {61'd0, z16, nf16, c16}, {61'd0, mz[0], mn[0], mc[0]});
      check($sformatf("flags32_%h", ins), {61'd0, z32, nf32, c32}, {61'd0, mz[1], mn[1], mc[1]});
   endtask

   task automatic idle();
      @(negedge Clock);
      Run = 1'b0;
   endtask

   task automatic chk_reg(input logic [2:0] idx, input logic [15:0] v16, input logic [31:0] v32);
      @(negedge Clock);
      DbgSel = idx;
      #1;
      check($sformatf("plan16_r%0d", idx), {48'd0, dbg16}, {48'd0, v16});
      check($sformatf("plan32_r%0d", idx), {32'd0, dbg32}, {32'd0, v32});
   endtask

   task automatic sweep();
      for (int i = 0; i < 8; i++) begin
         @(negedge Clock);
         DbgSel = 3'(i);
         #1;
         check($sformatf("sweep16_r%0d", i), {48'd0, dbg16}, mr[0][i]);
         check($sformatf("sweep32_r%0d", i), {32'd0, dbg32}, mr[1][i]);
      end
   endtask

   initial begin
      Reset = 1'b1;
      Run = 1'b0;
      DIN = '0;
      DbgSel = '0;
      model_reset();
      sweep();
      check("reset_done16", {63'd0, done16}, 64'd0);
      check("reset_flags16", {61'd0, z16, nf16, c16}, 64'd0);
      check("reset_flags32", {61'd0, z32, nf32, c32}, 64'd0);
      @(negedge Clock);
      Reset = 1'b0;

      // mv / mvt
      exec(enc(3'd0, 1'b1, 3'd0, 9'd5), 1'b0);
      exec(enc(3'd1, 1'b1, 3'd1, 9'h0AB), 1'b0);
      chk_reg(3'd0, 16'h0005, 32'h0000_0005);
      chk_reg(3'd1, 16'hAB00, 32'hAB00_0000);
      check("mv_flags16", {61'd0, z16, nf16, c16}, 64'd0);

      // add wraps to zero on N=16, then mvnz is suppressed there
      exec(enc(3'd1, 1'b1, 3'd2, 9'h0FF), 1'b0);
      exec(enc(3'd2, 1'b1, 3'd2, 9'h0FF), 1'b0);
      exec(enc(3'd2, 1'b1, 3'd2, 9'd1), 1'b0);
      chk_reg(3'd2, 16'h0000, 32'hFF00_0100);
      check("add_flags16", {61'd0, z16, nf16, c16}, {61'd0, 3'b101});
      exec(enc(3'd7, 1'b1, 3'd3, 9'd7), 1'b0);
      chk_reg(3'd3, 16'h0000, 32'h0000_0007);

      // cmp 3 vs 5, then mvnz writes
      exec(enc(3'd0, 1'b1, 3'd4, 9'd3), 1'b0);
      exec(enc(3'd5, 1'b1, 3'd4, 9'd5), 1'b0);
      chk_reg(3'd4, 16'h0003, 32'h0000_0003);
      check("cmp_flags16", {61'd0, z16, nf16, c16}, {61'd0, 3'b010});
      exec(enc(3'd7, 1'b1, 3'd5, 9'd9), 1'b0);
      chk_reg(3'd5, 16'h0009, 32'h0000_0009);

      // lsl by immediate, lsr by register amount that wraps
      exec(enc(3'd1, 1'b1, 3'd6, 9'h080), 1'b0);
      exec(enc(3'd2, 1'b1, 3'd6, 9'd1), 1'b0);
      exec(enc(3'd6, 1'b1, 3'd6, 9'h001), 1'b0);
      chk_reg(3'd6, 16'h0002, 32'h0000_0002);
      check("lsl_c32", {63'd0, c32}, 64'd1);
      exec(enc(3'd0, 1'b1, 3'd7, 9'd33), 1'b0);
      exec(enc(3'd6, 1'b0, 3'd6, 9'h107), 1'b0);
      chk_reg(3'd6, 16'h0001, 32'h0000_0001);
      check("lsr_c32", {63'd0, c32}, 64'd0);

      // back-to-back and + mv with Run held
      exec(enc(3'd1, 1'b1, 3'd0, 9'h00F), 1'b0);
      exec(enc(3'd2, 1'b1, 3'd0, 9'h00F), 1'b0);
      exec(enc(3'd0, 1'b1, 3'd1, 9'h0FF), 1'b0);
      exec(enc(3'd4, 1'b0, 3'd0, 9'd1), 1'b1);
      exec(enc(3'd0, 1'b0, 3'd2, 9'd0), 1'b0);
      chk_reg(3'd0, 16'h000F, 32'h0000_000F);
      chk_reg(3'd2, 16'h000F, 32'h0000_000F);

      // asynchronous reset in T2 of sub r1,r1
      exec(enc(3'd0, 1'b1, 3'd1, 9'd7), 1'b0);
      @(negedge Clock);
      DIN = enc(3'd3, 1'b0, 3'd1, 9'd1);
      Run = 1'b1;
      DbgSel = 3'd1;
      @(posedge Clock);
      #1;
      Run = 1'b0;
      @(posedge Clock);
      #2;
      Reset = 1'b1;
      #1;
      model_reset();
      check("rst_done16", {63'd0, done16}, 64'd0);
      check("rst_done32", {63'd0, done32}, 64'd0);
      check("rst_r1_16", {48'd0, dbg16}, 64'd0);
      check("rst_r1_32", {32'd0, dbg32}, 64'd0);
      check("rst_flags16", {61'd0, z16, nf16, c16}, 64'd0);
      @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
      exec(enc(3'd0, 1'b1, 3'd1, 9'd2), 1'b0);
      chk_reg(3'd1, 16'h0002, 32'h0000_0002);
      sweep();

      // random instruction stream
      for (int i = 0; i < 120; i++) begin
         exec(16'($urandom), 1'($urandom_range(0, 1)));
      end
      idle();
      sweep();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/proc_n.md
# proc_n

Parametrised successor to the course multicycle processor: same instruction encoding and Run/Done sequencing, with an N-bit datapath, reset-cleared register file, an expanded ALU (AND, compare, shifts), condition flags Z/Nf/C, and a flag-conditional move. It executes one instruction at a time from the 16-bit instruction word on DIN. A combinational debug read port exposes any register to the bench.

## Interface
- N, 16: datapath and register width; legal range 16..64. SW = ceil(log2(N)) is the shift-amount width.
- Clock  in  1  sole clock, rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- DIN  in  16  instruction word, captured into IR while in T0
- Run  in  1  start request, sampled in T0
- Done  out  1  combinational; high in the final step of each instruction
- Z, Nf, C  out  1 each  condition flag registers
- DbgSel  in  3  register index for the debug port
- DbgData  out  N  combinational copy of R[DbgSel]

## Operation
- Instruction format: III M XXX DDDDDDDDD. rX = IR[11:9]. rY = IR[2:0].
- Operand Op: if M=0, Op = R[rY]; if M=1, Op = zero-extended IR[8:0].
- 000 mv: rX <- Op.
- 001 mvt: rX <- {IR[7:0], (N-8) zeros}. M is ignored.
- 010 add: rX <- rX + Op.
- 011 sub: rX <- rX - Op.
- 100 and: rX <- rX & Op.
- 101 cmp: computes rX - Op; updates flags only, with no register write.
- 110 shift:
  - IR[8]=0 selects lsl, IR[8]=1 selects lsr. Both are logical with zero fill.
  - Amount = Op[SW-1:0], so an amount of N or more wraps modulo 2^SW. For immediate shifts IR[8] is the type bit, so Op = IR[7:0].
- 111 mvnz: if Z=0, rX <- Op; if Z=1, no write. It completes in one execute step either way.
- Flags are written on the same edge G is loaded (end of T2), and only by 010–110.
  - Z = (result == 0).
  - Nf = result[N-1].
  - C for add: carry out of bit N-1.
  - C for sub/cmp: 1 when rX >= Op unsigned (no borrow).
  - C for and: 0.
  - C for shift: last bit shifted out; 0 when amount = 0.
- mv, mvt and mvnz never change flags.
- Arithmetic wraps modulo 2^N.

## Timing
- States: T0 (fetch), T1, T2, T3. The step register is updated on Clock or asynchronously by Reset.
- T0:
  - IR loads DIN on every clock edge in T0, regardless of Run.
  - Run=1 moves to T1; Run=0 holds T0.
  - The instruction executed is the DIN present at the T0 edge where Run=1.
- T1, mv/mvt/mvnz: the register write happens at the end of T1. Done=1 in T1, then T0. Latency: 2 cycles from the Run edge to the next fetch.
- T1, ALU ops (010–110): A <- rX, then T2.
- T2: G <- f(A, Op) and flags update, then T3.
- T3:
  - 010–100 and 110: rX <- G.
  - 101: no register write.
  - Done=1 in T3, then T0.
- Done is 0 in T0 and T2, and in T1 for ALU ops.
- Run is ignored outside T0. Run held high gives back-to-back instructions, each taking 2 or 4 cycles.
- Register write and Done are asserted in the same cycle. The written value is visible on DbgData the cycle after Done.
- rX = rY: the operand is read before the write edge (for example, add r1,r1 doubles r1).
- Reset values, applied immediately on Reset (asynchronous), including mid-instruction:
  - step = T0, IR = 0, R0..R7 = 0, A = 0, G = 0, Z = Nf = C = 0, Done = 0.
  - An interrupted instruction has no architectural effect beyond writes already completed.
  - The first fetch occurs on the first Clock edge after Reset deasserts.

## Test plan
- N=16: mv r0,#5 then mvt r1,#0xAB → after the second Done, R0=0x0005 and R1=0xAB00. Each instruction shows Done exactly once, in its 2nd cycle. Flags stay 0.
- N=16: r2=0xFFFF, then add r2,#1 → R2=0x0000, Z=1, C=1, Nf=0. Done is in the 4th cycle. Then mvnz r3,#7 → R3 unchanged (0).
- N=16: r4=3, cmp r4,#5 → R4 still 3, Z=0, Nf=1, C=0. Then mvnz r5,#9 → R5=9.
- N=32: r6=0x80000001, lsl r6,#1 → R6=0x00000002, C=1. Then lsr with amount from r7=33 (wraps to 1) → R6=0x00000001, C=0.
- N=16: Reset asserted mid-T2 of sub r1,r1 with r1=7.
  - Done=0 and DbgData(R1)=0 immediately, without waiting for a clock edge.
  - After release, mv r1,#2 executes normally.
- Run held high across and r0,r1 (0x0F0F & 0x00FF) followed by mv r2,r0 → R0=0x000F, then R2=0x000F. Done pulses in cycles 4 and 6 of the sequence, counted from the first Run=1 T0 edge.
